booth_r4_mult_seq: RTL and testbench
====================================

Name: booth_r4_mult_seq

Overview:
Parametrised sequential radix-4 Booth multiplier: the next-generation replacement for the fixed 32x32 signed Radix4 multiplier.
- Adds generic operand width, a per-operation signed/unsigned mode, and a start/busy/done handshake, so callers no longer hold reset high to load operands.
- Retires one Booth digit per clock.
- Sits in the datapath wherever a multi-cycle, minimum-area multiply is acceptable.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4; product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request new multiply; sampled on rising clk
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
inputM  input  WIDTH  multiplicand; sampled with start
inputQ  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: product just updated
out  output  2*WIDTH  product register; holds last result

Behaviour:
- Reset (async assert, any state):
  - state = IDLE.
  - busy = 0, done = 0, out = 0.
  - All internal registers cleared.
  - An in-flight operation is discarded with no done pulse.
  - Operation resumes on the first rising clk after reset deasserts.
- Operand extension:
  - Operands are extended to WIDTH+2 bits: sign-extended if signed_mode = 1, zero-extended otherwise.
  - Digit count N = WIDTH/2 + 1 (17 for WIDTH=32), the same for both modes.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy = 0, done = 0.
  - start = 1 at an edge: latch inputM, inputQ, signed_mode; clear accumulator and digit counter; go to RUN.
  - start = 0: remain in IDLE.
- RUN:
  - busy = 1.
  - Each edge consumes digit i (i = 0..N-1) formed from extended multiplier bits {q[2i+1], q[2i], q[2i-1]}, with q[-1] = 0.
  - Digit encoding: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - The partial product is added at weight 4^i (shift-accumulate). The accumulator is wide enough that no overflow occurs.
  - On the edge consuming digit N-1: out <= low 2*WIDTH bits of the accumulated sum; go to DONE.
  - start is ignored in RUN; operand inputs may change freely.
- DONE:
  - Lasts exactly one cycle: busy = 0, done = 1.
  - start = 1 at this edge: accepted exactly as in IDLE (back-to-back operation, next state RUN).
  - Otherwise: go to IDLE.
- Latency:
  - start sampled at edge E0 -> busy high from E0 -> out updated and done high at edge E0+N.
  - Throughput: one result per N+1 cycles when start is held high.
- out is registered and changes only at the DONE transition or on reset; it is stable between results.
- Results:
  - signed_mode = 1: out = two's-complement product of the signed operands.
  - signed_mode = 0: out = unsigned product.
  - Both are exact for all operand values, including most-negative x most-negative and all-ones x all-ones.
- No X propagation: out must not go X for any defined inputs after reset.

Test Plan:
1. WIDTH=32, signed:
   - 7 x 2 -> out = 14, done exactly 17 cycles after the start edge.
   - 0xFFFFFFFE x 0xFFFFFFFB -> 10.
   - 0xFFFFFFFB x 2 -> 0xFFFFFFFFFFFFFFF6.
   - 0xFFFFFF01 x 0x00000139 -> -79815.
2. WIDTH=32, mode contrast on the same operands 0xFFFFFFFF x 0xFFFFFFFF:
   - signed -> 1.
   - unsigned -> 0xFFFFFFFE00000001.
   - Zero operand with 0xF00000F5 -> 0.
   - 1 x 0xCF -> 0xCF.
3. WIDTH=8 instance, N = 5:
   - signed 0x80 x 0x80 -> 0x4000.
   - unsigned 0xFF x 0xFF -> 0xFE01.
   - signed 0x7F x 0x80 -> 0xC080.
   - done at start edge + 5.
4. Handshake:
   - start pulsed again mid-RUN with different operands -> ignored; first result is unchanged and produces exactly one done pulse.
   - start held high continuously -> a new result every N+1 cycles, with busy low only during the DONE cycles.
5. Reset mid-operation:
   - Assert reset asynchronously (between edges) 8 cycles into RUN -> busy, done and out read 0 immediately, and no done pulse follows.
   - Next start after release -> correct product with full latency.
6. Hold:
   - After a result, keep start low for 50 cycles and toggle inputM/inputQ -> out stays constant, and busy and done stay 0.

Source files
------------

// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier, one Booth digit per clock.
// Handshake: start is sampled in IDLE or DONE; busy marks RUN; done pulses for the one cycle after out updates.
module booth_r4_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     inputM,
  input  logic [WIDTH-1:0]     inputQ,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);

  localparam int PW = 2 * WIDTH;
  localparam int EW = WIDTH + 2;
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0] m_sh;
  logic [EW-1:0] q_sh;
  logic          q_prev;
  logic [PW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pp;
  logic [PW-1:0] m_ext;
  logic [EW-1:0] q_ext;
  logic          load;
  logic          last;

  assign load  = start && (state == IDLE || state == DONE);
  assign last  = (cnt == CW'(N - 1));
  assign m_ext = {{WIDTH{signed_mode & inputM[WIDTH-1]}}, inputM};
  assign q_ext = {{2{signed_mode & inputQ[WIDTH-1]}}, inputQ};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Partial product for the current digit; m_sh already carries weight 4^i.
  always_comb begin
    pp = '0;
    unique case ({q_sh[1:0], q_prev})
      3'b001, 3'b010: pp = m_sh;
      3'b011:         pp = m_sh << 1;
      3'b100:         pp = -(m_sh << 1);
      3'b101, 3'b110: pp = -m_sh;
      default:        pp = '0;
    endcase
  end

  // Arithmetic is modulo 2^PW, so the low PW bits of the sum are exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sh   <= '0;
      q_sh   <= '0;
      q_prev <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      m_sh   <= m_ext;
      q_sh   <= q_ext;
      q_prev <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc + pp;
      m_sh   <= m_sh << 2;
      q_sh   <= q_sh >> 2;
      q_prev <= q_sh[1];
      cnt    <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     out <= '0;
    else if (state == RUN && last) out <= acc + pp;
  end

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// Bench for booth_r4_mult_seq: 32-bit and 8-bit instances, vector tables, random ops against a plain-arithmetic model.
module tb_booth_r4_mult_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start32 = 1'b0, sm32 = 1'b0, busy32, done32;
  logic [31:0] m32 = '0, q32 = '0;
  logic [63:0] out32;
  logic        start8 = 1'b0, sm8 = 1'b0, busy8, done8;
  logic [7:0]  m8 = '0, q8 = '0;
  logic [15:0] out8;

  booth_r4_mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .signed_mode(sm32),
    .inputM(m32), .inputQ(q32), .busy(busy32), .done(done32), .out(out32)
  );

  booth_r4_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .inputM(m8), .inputQ(q8), .busy(busy8), .done(done8), .out(out8)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_pulses32 = 0;

  always @(negedge clk) if (done32 === 1'b1) done_pulses32++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: interpret operands as integers of width w, multiply, keep 2w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q,
                                          input bit s, input int w);
    longint a, b, p;
    a = longint'(m);
    b = longint'(q);
    if (s && m[w-1]) a = a - (longint'(1) << w);
    if (s && q[w-1]) b = b - (longint'(1) << w);
    p = a * b;
    if (w < 32) p = p & ((longint'(1) << (2 * w)) - 1);
    return 64'(p);
  endfunction

  task automatic run32(input logic [31:0] m, input logic [31:0] q, input bit s,
                       output logic [63:0] res, output int lat);
    @(negedge clk);
    start32 = 1'b1; m32 = m; q32 = q; sm32 = s;
    @(negedge clk);
    start32 = 1'b0; m32 = $urandom; q32 = $urandom; sm32 = 1'($urandom_range(0, 1));
    lat = 0;
    while (done32 !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = out32;
  endtask

  task automatic run8(input logic [7:0] m, input logic [7:0] q, input bit s,
                      output logic [15:0] res, output int lat);
    @(negedge clk);
    start8 = 1'b1; m8 = m; q8 = q; sm8 = s;
    @(negedge clk);
    start8 = 1'b0; m8 = 8'($urandom); q8 = 8'($urandom);
    lat = 0;
    while (done8 !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = out8;
  endtask

  typedef struct {
    logic [31:0] m;
    logic [31:0] q;
    bit          s;
    logic [63:0] exp;
  } vec32_t;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    bit          s;
    logic [15:0] exp;
  } vec8_t;

  vec32_t v32[10];
  vec8_t  v8[3];

  initial begin
    logic [63:0] r64;
    logic [15:0] r16;
    logic [63:0] exp64;
    logic [31:0] corner[5];
    int lat, bad, k, last_t, prev_pulses;

    v32[0] = '{32'd7,         32'd2,         1'b1, 64'd14};
    v32[1] = '{32'hFFFFFFFE, 32'hFFFFFFFB, 1'b1, 64'd10};
    v32[2] = '{32'hFFFFFFFB, 32'd2,         1'b1, 64'hFFFFFFFFFFFFFFF6};
    v32[3] = '{32'hFFFFFF01, 32'h00000139, 1'b1, 64'hFFFFFFFFFFFEC839};
    v32[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1};
    v32[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    v32[6] = '{32'd0,         32'hF00000F5, 1'b1, 64'd0};
    v32[7] = '{32'd1,         32'h000000CF, 1'b0, 64'hCF};
    v32[8] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    v32[9] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000};
    v8[0]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    v8[1]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    v8[2]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    corner = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h7FFFFFFF};

    // Reset state
    @(negedge clk);
    chk("reset_busy32", {63'd0, busy32}, 64'd0);
    chk("reset_done32", {63'd0, done32}, 64'd0);
    chk("reset_out32", out32, 64'd0);
    chk("reset_out8", {48'd0, out8}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run32(v32[i].m, v32[i].q, v32[i].s, r64, lat);
      chk($sformatf("vec32_%0d", i), r64, v32[i].exp);
      chk($sformatf("vec32_lat_%0d", i), 64'(lat), 64'd17);
    end

    for (int i = 0; i < 3; i++) begin
      run8(v8[i].m, v8[i].q, v8[i].s, r16, lat);
      chk($sformatf("vec8_%0d", i), {48'd0, r16}, {48'd0, v8[i].exp});
      chk($sformatf("vec8_lat_%0d", i), 64'(lat), 64'd5);
    end

    for (int i = 0; i < 40; i++) begin
      logic [31:0] m, q;
      bit s;
      m = (i % 4 == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      q = (i % 3 == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      s = 1'($urandom_range(0, 1));
      run32(m, q, s, r64, lat);
      chk($sformatf("rand32_%0d", i), r64, ref_mul(m, q, s, 32));
      if (i % 8 == 0) chk($sformatf("rand32_lat_%0d", i), 64'(lat), 64'd17);
    end

    for (int i = 0; i < 30; i++) begin
      logic [7:0] m, q;
      bit s;
      m = 8'($urandom);
      q = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      run8(m, q, s, r16, lat);
      chk($sformatf("rand8_%0d", i), {48'd0, r16}, ref_mul({24'd0, m}, {24'd0, q}, s, 8));
    end

    // start pulsed mid-RUN with different operands is ignored
    prev_pulses = done_pulses32;
    @(negedge clk);
    start32 = 1'b1; m32 = 32'd1234; q32 = 32'd5678; sm32 = 1'b0;
    @(negedge clk);
    start32 = 1'b0;
    repeat (3) @(negedge clk);
    start32 = 1'b1; m32 = 32'hDEADBEEF; q32 = 32'h0BADF00D; sm32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrun_result", out32, 64'd7006652);
    chk("midrun_one_done", 64'(done_pulses32 - prev_pulses), 64'd1);
    chk("midrun_idle", {63'd0, busy32}, 64'd0);

    // start held high: a result every N+1 cycles, busy low only in DONE
    @(negedge clk);
    start32 = 1'b1; sm32 = 1'b1; m32 = 32'd3; q32 = 32'hFFFFFFF9;
    exp64 = ref_mul(32'd3, 32'hFFFFFFF9, 1'b1, 32);
    k = 0; bad = 0; last_t = -1;
    for (int c = 0; c < 100 && k < 4; c++) begin
      @(negedge clk);
      if (done32 === 1'b1) begin
        chk($sformatf("b2b_result_%0d", k), out32, exp64);
        if (last_t >= 0) chk($sformatf("b2b_period_%0d", k), 64'(c - last_t), 64'd18);
        else chk("b2b_first_lat", 64'(c), 64'd17);
        last_t = c;
        k++;
        m32 = $urandom; q32 = $urandom;
        exp64 = ref_mul(m32, q32, 1'b1, 32);
        if (k == 4) start32 = 1'b0;
      end else if (busy32 !== 1'b1) bad++;
    end
    chk("b2b_count", 64'(k), 64'd4);
    chk("b2b_busy", 64'(bad), 64'd0);
    start32 = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset 8 cycles into RUN
    @(negedge clk);
    start32 = 1'b1; m32 = 32'd99; q32 = 32'd77; sm32 = 1'b0;
    @(negedge clk);
    start32 = 1'b0;
    repeat (8) @(negedge clk);
    prev_pulses = done_pulses32;
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy32}, 64'd0);
    chk("arst_done", {63'd0, done32}, 64'd0);
    chk("arst_out", out32, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("arst_no_done", 64'(done_pulses32 - prev_pulses), 64'd0);
    run32(32'hFFFFFF01, 32'h00000139, 1'b1, r64, lat);
    chk("arst_next_result", r64, 64'hFFFFFFFFFFFEC839);
    chk("arst_next_lat", 64'(lat), 64'd17);

    // Hold: out stable, no activity while start stays low
    run32(32'h12345678, 32'h9ABCDEF0, 1'b0, r64, lat);
    exp64 = ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b0, 32);
    chk("hold_result", r64, exp64);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      m32 = $urandom; q32 = $urandom; sm32 = 1'($urandom_range(0, 1));
      if (c > 0 && (out32 !== exp64 || busy32 !== 1'b0 || done32 !== 1'b0)) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
